// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined RV32I control path: opcodes, ALU
// operation codes, immediate formats and the packed ID/EX control bundle.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    result_src_t result_src;
    logic        alu_src;
    logic        alu_a_pc;
    alu_ctrl_t   alu_ctrl;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
  } ctrl_bundle_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational RV32I decoder: instruction word to EX control bundle,
// sign-extended immediate, source-register usage and an illegal flag.
module instr_decode
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instr,
  output ctrl_bundle_t          ctrl,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  rs1_used,
  output logic                  rs2_used,
  output logic                  illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm32;
  logic        has_imm;
  imm_type_t   imm_sel;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  always_comb begin
    ctrl     = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    has_imm  = 1'b0;
    imm_sel  = IMM_I;
    case (opcode)
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_PASS_B;
        has_imm        = 1'b1;
        imm_sel        = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_a_pc  = 1'b1;
        has_imm        = 1'b1;
        imm_sel        = IMM_U;
      end
      OPC_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_a_pc   = 1'b1;
        ctrl.result_src = RES_PC4;
        has_imm         = 1'b1;
        imm_sel         = IMM_J;
      end
      OPC_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.funct3     = funct3;
        rs1_used        = 1'b1;
        has_imm         = 1'b1;
        illegal         = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.funct3 = funct3;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        has_imm     = 1'b1;
        imm_sel     = IMM_B;
        case (funct3)
          3'b000, 3'b001: ctrl.alu_ctrl = ALU_SUB;
          3'b100, 3'b101: ctrl.alu_ctrl = ALU_SLT;
          3'b110, 3'b111: ctrl.alu_ctrl = ALU_SLTU;
          default:        illegal       = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.funct3     = funct3;
        rs1_used        = 1'b1;
        has_imm         = 1'b1;
        illegal         = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.funct3    = funct3;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        has_imm        = 1'b1;
        imm_sel        = IMM_S;
        illegal        = (funct3[2] == 1'b1) || (funct3 == 3'b011);
      end
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.funct3    = funct3;
        rs1_used       = 1'b1;
        has_imm        = 1'b1;
        case (funct3)
          3'b000: ctrl.alu_ctrl = ALU_ADD;
          3'b010: ctrl.alu_ctrl = ALU_SLT;
          3'b011: ctrl.alu_ctrl = ALU_SLTU;
          3'b100: ctrl.alu_ctrl = ALU_XOR;
          3'b110: ctrl.alu_ctrl = ALU_OR;
          3'b111: ctrl.alu_ctrl = ALU_AND;
          3'b001: begin
            ctrl.alu_ctrl = ALU_SLL;
            illegal       = (funct7 != 7'h00);
          end
          default: begin
            ctrl.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
            illegal       = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
        endcase
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.funct3    = funct3;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        case (funct3)
          3'b000:  ctrl.alu_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl.alu_ctrl = ALU_SLL;
          3'b010:  ctrl.alu_ctrl = ALU_SLT;
          3'b011:  ctrl.alu_ctrl = ALU_SLTU;
          3'b100:  ctrl.alu_ctrl = ALU_XOR;
          3'b101:  ctrl.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl.alu_ctrl = ALU_OR;
          default: ctrl.alu_ctrl = ALU_AND;
        endcase
        illegal = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      default: illegal = 1'b1;
    endcase

    // Illegal encodings carry no side effects and never create a hazard.
    if (illegal) begin
      ctrl     = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      has_imm  = 1'b0;
    end
    if (rd == 5'd0)
      ctrl.reg_write = 1'b0;
  end

  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'h000};
      default: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  end

  assign imm = has_imm ? DATA_WIDTH'($signed(imm32)) : '0;

endmodule

// File: rtl/pipe_control.sv
// Pipelined control: D-stage decode, ID/EX control register, load-use and
// control hazard handling. Optional illegal_e output under PIPE_CTRL_ILLEGAL_EN.
module pipe_control
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     instr_d,
  input  logic                      valid_d,
  input  logic [DATA_WIDTH-1:0]     pc_d,
  input  logic                      branch_taken_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      valid_e,
  output logic                      reg_write_e,
  output logic                      mem_write_e,
  output logic                      mem_read_e,
  output logic [1:0]                result_src_e,
  output logic                      alu_src_e,
  output logic                      alu_a_pc_e,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_e,
  output logic                      branch_e,
  output logic                      jump_e,
  output logic                      jalr_e,
  output logic [2:0]                funct3_e,
  output logic [DATA_WIDTH-1:0]     imm_e,
  output logic [REG_ADDR_WIDTH-1:0] rs1_e,
  output logic [REG_ADDR_WIDTH-1:0] rs2_e,
  output logic [REG_ADDR_WIDTH-1:0] rd_e,
  output logic [DATA_WIDTH-1:0]     pc_e
`ifdef PIPE_CTRL_ILLEGAL_EN
  ,
  output logic                      illegal_e
`endif
);

  ctrl_bundle_t              dec_ctrl;
  logic [DATA_WIDTH-1:0]     dec_imm;
  logic                      dec_rs1_used;
  logic                      dec_rs2_used;
  logic                      dec_illegal;
  logic [REG_ADDR_WIDTH-1:0] rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_d;

  ctrl_bundle_t              ctrl_q;
  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  logic load_use;
  logic capture;

  instr_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_decode (
    .instr   (instr_d),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .rs1_used(dec_rs1_used),
    .rs2_used(dec_rs2_used),
    .illegal (dec_illegal)
  );

  assign rs1_d = REG_ADDR_WIDTH'(instr_d[19:15]);
  assign rs2_d = REG_ADDR_WIDTH'(instr_d[24:20]);
  assign rd_d  = REG_ADDR_WIDTH'(instr_d[11:7]);

  assign load_use = valid_q && ctrl_q.mem_read && (rd_q != '0) && valid_d &&
                    ((dec_rs1_used && (rd_q == rs1_d)) ||
                     (dec_rs2_used && (rd_q == rs2_d)));

  // A taken redirect kills the D instruction, so any load-use stall is moot.
  assign flush_d = !rst && branch_taken_e;
  assign stall_f = !rst && !branch_taken_e && load_use;
  assign stall_d = stall_f;

  assign capture = valid_d && !dec_illegal && !branch_taken_e && !load_use;

  always_ff @(posedge clk) begin
    if (rst || !capture) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      imm_q   <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= dec_ctrl;
      valid_q <= 1'b1;
      imm_q   <= dec_imm;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

`ifdef PIPE_CTRL_ILLEGAL_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else
      illegal_q <= valid_d && dec_illegal && !branch_taken_e && !load_use;
  end

  assign illegal_e = illegal_q;
`endif

  assign valid_e      = valid_q;
  assign reg_write_e  = ctrl_q.reg_write;
  assign mem_write_e  = ctrl_q.mem_write;
  assign mem_read_e   = ctrl_q.mem_read;
  assign result_src_e = ctrl_q.result_src;
  assign alu_src_e    = ctrl_q.alu_src;
  assign alu_a_pc_e   = ctrl_q.alu_a_pc;
  assign alu_ctrl_e   = ALU_CTRL_WIDTH'(ctrl_q.alu_ctrl);
  assign branch_e     = ctrl_q.branch;
  assign jump_e       = ctrl_q.jump;
  assign jalr_e       = ctrl_q.jalr;
  assign funct3_e     = ctrl_q.funct3;
  assign imm_e        = imm_q;
  assign rs1_e        = rs1_q;
  assign rs2_e        = rs2_q;
  assign rd_e         = rd_q;
  assign pc_e         = pc_q;

endmodule

// File: tb/tb_pipe_control.sv
// Table-driven bench for pipe_control: per-cycle vectors with hand-computed
// stall/flush and ID/EX expectations, plus short store/illegal sequences.
module tb_pipe_control;

  logic        clk;
  logic        rst;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [31:0] pc_d;
  logic        branch_taken_e;
  logic        stall_f, stall_d, flush_d, valid_e;
  logic        reg_write_e, mem_write_e, mem_read_e;
  logic [1:0]  result_src_e;
  logic        alu_src_e, alu_a_pc_e;
  logic [3:0]  alu_ctrl_e;
  logic        branch_e, jump_e, jalr_e;
  logic [2:0]  funct3_e;
  logic [31:0] imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] pc_e;
`ifdef PIPE_CTRL_ILLEGAL_EN
  logic        illegal_e;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pipe_control #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .ALU_CTRL_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
    .branch_taken_e(branch_taken_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .valid_e(valid_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .mem_read_e(mem_read_e), .result_src_e(result_src_e),
    .alu_src_e(alu_src_e), .alu_a_pc_e(alu_a_pc_e), .alu_ctrl_e(alu_ctrl_e),
    .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e),
    .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e)
`ifdef PIPE_CTRL_ILLEGAL_EN
    , .illegal_e(illegal_e)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        vd;
    logic        bt;
    logic        stall;
    logic        flush;
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jmp;
    logic        asrc;
    logic [1:0]  res;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
  } vec_t;

  function automatic vec_t mk(logic r, logic [31:0] ins, logic vd, logic bt,
                              logic st, logic fl, logic v, logic rw, logic mr,
                              logic mw, logic br, logic jmp, logic asrc,
                              logic [1:0] res, logic [3:0] alu, logic [4:0] rd,
                              logic [4:0] rs1, logic [31:0] imm);
    vec_t t;
    t.rst = r; t.instr = ins; t.vd = vd; t.bt = bt; t.stall = st; t.flush = fl;
    t.valid = v; t.rw = rw; t.mr = mr; t.mw = mw; t.br = br; t.jmp = jmp;
    t.asrc = asrc; t.res = res; t.alu = alu; t.rd = rd; t.rs1 = rs1; t.imm = imm;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRAI  = 32'h4050D293;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_ADDI5 = 32'h00128313;
  localparam logic [31:0] I_ADDI0 = 32'h00100313;
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_DEP2  = 32'h005083B3;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_LUI   = 32'h12345537;
  localparam logic [31:0] I_NOP   = 32'h00000013;
  localparam logic [31:0] I_SW    = 32'h00512223;

  vec_t vecs[23];

  initial begin
    logic [31:0]  pc;
    logic [31:0]  exp_pc;
    logic [127:0] got_v, exp_v;

    //              rst instr   vd bt st fl  v rw mr mw br jp as res alu rd rs1 imm
    vecs[0]  = mk(1, I_ADD,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 32'h0);
    vecs[1]  = mk(1, I_ADD,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 32'h0);
    vecs[2]  = mk(0, I_ADD,   1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0,  3, 1, 32'h0);
    vecs[3]  = mk(0, I_SUB,   1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,  1,  3, 1, 32'h0);
    vecs[4]  = mk(0, I_SRAI,  1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0,  9,  5, 1, 32'h405);
    vecs[5]  = mk(0, I_LW,    1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1,  0,  5, 1, 32'h0);
    vecs[6]  = mk(0, I_ADDI5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 32'h0);
    vecs[7]  = mk(0, I_ADDI5, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0,  0,  6, 5, 32'h1);
    vecs[8]  = mk(0, I_LW,    1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1,  0,  5, 1, 32'h0);
    vecs[9]  = mk(0, I_ADDI0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0,  0,  6, 0, 32'h1);
    vecs[10] = mk(0, I_LW,    1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1,  0,  5, 1, 32'h0);
    vecs[11] = mk(0, I_ADDI5, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 32'h0);
    vecs[12] = mk(0, I_BEQ,   1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0,  1, 29, 0, 32'hFFFFFFFC);
    vecs[13] = mk(0, I_BAD,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 32'h0);
    vecs[14] = mk(0, I_ADD,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 32'h0);
    vecs[15] = mk(0, I_LW,    1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1,  0,  5, 1, 32'h0);
    vecs[16] = mk(1, I_DEP2,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 32'h0);
    vecs[17] = mk(0, I_LW,    1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1,  0,  5, 1, 32'h0);
    vecs[18] = mk(0, I_DEP2,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 32'h0);
    vecs[19] = mk(0, I_DEP2,  1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0,  7, 1, 32'h0);
    vecs[20] = mk(0, I_JAL,   1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 2,  0,  1, 0, 32'h8);
    vecs[21] = mk(0, I_LUI,   1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 10, 10, 8, 32'h12345000);
    vecs[22] = mk(0, I_NOP,   1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 32'h0);

    rst = 1'b1; instr_d = '0; valid_d = 1'b0; pc_d = '0; branch_taken_e = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      pc = 32'h1000 + 32'(i) * 4;
      rst = vecs[i].rst; instr_d = vecs[i].instr; valid_d = vecs[i].vd;
      branch_taken_e = vecs[i].bt; pc_d = pc;
      #2;
      check($sformatf("vec%0d_hazard", i), {125'd0, stall_f, stall_d, flush_d},
            {125'd0, vecs[i].stall, vecs[i].stall, vecs[i].flush});
      @(posedge clk);
      #1;
      exp_pc = vecs[i].valid ? pc : 32'h0;
      got_v = {42'd0, valid_e, reg_write_e, mem_read_e, mem_write_e, branch_e, jump_e,
               alu_src_e, result_src_e, alu_ctrl_e, rd_e, rs1_e, imm_e, pc_e};
      exp_v = {42'd0, vecs[i].valid, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].br,
               vecs[i].jmp, vecs[i].asrc, vecs[i].res, vecs[i].alu, vecs[i].rd,
               vecs[i].rs1, vecs[i].imm, exp_pc};
      check($sformatf("vec%0d_idex", i), got_v, exp_v);
    end

    // Store: operand B from immediate, rs2 carries the data register.
    rst = 1'b0; instr_d = I_SW; valid_d = 1'b1; branch_taken_e = 1'b0; pc_d = 32'h2000;
    @(posedge clk);
    #1;
    check("sw_ctrl", {122'd0, mem_write_e, reg_write_e, mem_read_e, funct3_e},
          {122'd0, 1'b1, 1'b0, 1'b0, 3'b010});
    check("sw_fields", {91'd0, rs2_e, imm_e}, {91'd0, 5'd5, 32'h4});

    // Load followed by a store that depends on it through rs2 only.
    instr_d = I_LW;
    @(posedge clk);
    #1;
    instr_d = 32'h00512223 & ~32'h000F8000;  // sw x5,4(x0)
    #2;
    check("sw_rs2_stall", {126'd0, stall_f, stall_d}, {126'd0, 2'b11});
    @(posedge clk);
    #1;
    check("sw_rs2_bubble", {127'd0, valid_e}, {127'd0, 1'b0});

`ifdef PIPE_CTRL_ILLEGAL_EN
    instr_d = I_BAD; valid_d = 1'b1;
    @(posedge clk);
    #1;
    check("illegal_valid", {126'd0, illegal_e, reg_write_e}, {126'd0, 2'b10});
    valid_d = 1'b0;
    @(posedge clk);
    #1;
    check("illegal_bubble", {127'd0, illegal_e}, {127'd0, 1'b0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
